// File: rtl/rtc_core_if.sv
// Button/switch inputs and display-facing outputs of the millennium clock core.
interface rtc_core_if;
   logic        btn_mode;
   logic        btn_inc;
   logic        sw_date;
   logic [4:0]  hour;
   logic [5:0]  min;
   logic [5:0]  sec;
   logic [5:0]  day;
   logic [3:0]  month;
   logic [11:0] year;
   logic        clk_1hz;
   logic        mode_date;
   logic        set_sec;
   logic        set_min;
   logic        set_hour;
   logic        set_day;
   logic        set_month;
   logic        set_year;

   modport master (
      output btn_mode, btn_inc, sw_date,
      input  hour, min, sec, day, month, year, clk_1hz, mode_date,
      input  set_sec, set_min, set_hour, set_day, set_month, set_year
   );

   modport slave (
      input  btn_mode, btn_inc, sw_date,
      output hour, min, sec, day, month, year, clk_1hz, mode_date,
      output set_sec, set_min, set_hour, set_day, set_month, set_year
   );
endinterface

// File: rtl/rtc_core.sv
// 1 Hz divider, time-of-day + Gregorian calendar (2000-2999) and button-driven set FSM.
// Tick, btn_mode and btn_inc all reach the registered outputs one cycle later; no backpressure.
module rtc_core #(
   parameter int CLK_HZ = 50_000_000
) (
   input  logic      clk,
   input  logic      rst,
   rtc_core_if.slave bus
);

   localparam int DW = $clog2(CLK_HZ);

   localparam logic [2:0] RUN     = 3'd0;
   localparam logic [2:0] S_HOUR  = 3'd1;
   localparam logic [2:0] S_MIN   = 3'd2;
   localparam logic [2:0] S_SEC   = 3'd3;
   localparam logic [2:0] S_DAY   = 3'd4;
   localparam logic [2:0] S_MONTH = 3'd5;
   localparam logic [2:0] S_YEAR  = 3'd6;

   logic [DW-1:0] div_cnt, div_nxt;
   logic          tick;
   logic          clk_1hz_q;
   logic [2:0]    state_q, state_nxt;
   logic [5:0]    set_q;
   logic [4:0]    hour_q, n_hour;
   logic [5:0]    min_q, n_min;
   logic [5:0]    sec_q, n_sec;
   logic [5:0]    day_q, n_day, dmax;
   logic [3:0]    month_q, n_month;
   logic [11:0]   year_q, n_year;

   function automatic logic [5:0] dim_of(input logic [3:0] m, input logic [11:0] y);
      logic leap;
      leap = (y[1:0] == 2'b00) && (((y % 12'd100) != 12'd0) || ((y % 12'd400) == 12'd0));
      case (m)
         4'd2:                      return leap ? 6'd29 : 6'd28;
         4'd4, 4'd6, 4'd9, 4'd11:   return 6'd30;
         default:                   return 6'd31;
      endcase
   endfunction

   assign tick    = (div_cnt == DW'(CLK_HZ - 1));
   assign div_nxt = tick ? '0 : div_cnt + 1'b1;

   always_comb begin
      state_nxt = state_q;
      if (bus.btn_mode)
         state_nxt = (state_q == S_YEAR) ? RUN : state_q + 3'd1;
   end

   always_comb begin
      n_hour  = hour_q;
      n_min   = min_q;
      n_sec   = sec_q;
      n_day   = day_q;
      n_month = month_q;
      n_year  = year_q;
      dmax    = 6'd31;
      if (state_q == RUN) begin
         if (tick) begin
            if (sec_q != 6'd59) n_sec = sec_q + 6'd1;
            else begin
               n_sec = 6'd0;
               if (min_q != 6'd59) n_min = min_q + 6'd1;
               else begin
                  n_min = 6'd0;
                  if (hour_q != 5'd23) n_hour = hour_q + 5'd1;
                  else begin
                     n_hour = 5'd0;
                     if (day_q < dim_of(month_q, year_q)) n_day = day_q + 6'd1;
                     else begin
                        n_day = 6'd1;
                        if (month_q != 4'd12) n_month = month_q + 4'd1;
                        else begin
                           n_month = 4'd1;
                           n_year  = (year_q >= 12'd2999) ? 12'd2000 : year_q + 12'd1;
                        end
                     end
                  end
               end
            end
         end
      end else if (bus.btn_inc && !bus.btn_mode) begin
         case (state_q)
            S_HOUR:  n_hour  = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
            S_MIN:   n_min   = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
            S_SEC:   n_sec   = (sec_q >= 6'd59) ? 6'd0 : sec_q + 6'd1;
            S_DAY:   n_day   = (day_q >= dim_of(month_q, year_q)) ? 6'd1 : day_q + 6'd1;
            S_MONTH: n_month = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
            S_YEAR:  n_year  = (year_q >= 12'd2999) ? 12'd2000 : year_q + 12'd1;
            default: ;
         endcase
      end
      // A month or year change must never leave the day past the end of the new month.
      if ((n_month != month_q) || (n_year != year_q)) begin
         dmax = dim_of(n_month, n_year);
         if (n_day > dmax) n_day = dmax;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt   <= '0;
         clk_1hz_q <= 1'b1;
         state_q   <= RUN;
         set_q     <= '0;
         hour_q    <= 5'd0;
         min_q     <= 6'd0;
         sec_q     <= 6'd0;
         day_q     <= 6'd1;
         month_q   <= 4'd1;
         year_q    <= 12'd2000;
      end else begin
         div_cnt   <= div_nxt;
         clk_1hz_q <= (div_nxt < DW'(CLK_HZ / 2));
         state_q   <= state_nxt;
         set_q     <= {state_nxt == S_YEAR, state_nxt == S_MONTH, state_nxt == S_DAY,
                       state_nxt == S_HOUR, state_nxt == S_MIN, state_nxt == S_SEC};
         hour_q    <= n_hour;
         min_q     <= n_min;
         sec_q     <= n_sec;
         day_q     <= n_day;
         month_q   <= n_month;
         year_q    <= n_year;
      end
   end

   assign bus.hour      = hour_q;
   assign bus.min       = min_q;
   assign bus.sec       = sec_q;
   assign bus.day       = day_q;
   assign bus.month     = month_q;
   assign bus.year      = year_q;
   assign bus.clk_1hz   = clk_1hz_q;
   assign bus.set_sec   = set_q[0];
   assign bus.set_min   = set_q[1];
   assign bus.set_hour  = set_q[2];
   assign bus.set_day   = set_q[3];
   assign bus.set_month = set_q[4];
   assign bus.set_year  = set_q[5];
   assign bus.mode_date = (state_q == RUN) ? bus.sw_date : (state_q >= S_DAY);

endmodule
